// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_arb_pkg;

  // Default geometry of the 32x8 data memory.
  localparam int unsigned DEF_ADDR_W    = 8;
  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_MEM_DEPTH = 32;

  // Arbiter FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // Requester identifiers; also the bit position of each port in the request vector.
  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

  // The port that is not `id`; used to hand a tie to whoever did not win last.
  function automatic logic other_port(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
// The arbiter uses the slave view; requesters plus memory together use the master view.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  // Port A (CPU load/store stage)
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              a_err;

  // Port B (debug / DMA loader)
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              b_err;

  // Data memory side
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata, a_err,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata, b_err,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata, a_err,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata, b_err,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin picker. Purely combinational: a single request wins outright,
// a tie goes to the port that did not receive the previous grant.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,         // bit GNT_A = port A, bit GNT_B = port B
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Select the winner from the request pattern and the previous grant.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = GNT_A;
    unique case (req)
      2'b01:   gnt_id = GNT_A;
      2'b10:   gnt_id = GNT_B;
      2'b11:   gnt_id = other_port(last_grant);
      default: gnt_id = GNT_A;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between port A (CPU) and
// port B (debug/DMA). Each access is IDLE -> CMD -> RESP: the request is latched in IDLE,
// the memory strobe is driven for the single CMD cycle (memory acts on the falling edge),
// and the granted port gets a one-cycle ack in RESP.
// Optional build macro DMEM_ARB_BOUNDS_CHECK_EN: addresses >= MEM_DEPTH are not sent to
// the memory and complete with err = 1 and rdata = 0, keeping the same 3-cycle timing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic          CLK,
  input  logic          RST,
  dmem_arbiter_if.slave bus,
  output logic          busy
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BoundsEn = 1'b1;
`else
  localparam bit BoundsEn = 1'b0;
`endif

  // One extra bit so a depth equal to 2**ADDR_W is still representable.
  localparam logic [ADDR_W:0] DepthLimit = (ADDR_W + 1)'(MEM_DEPTH);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_valid;
  logic              gnt_id;
  logic              oob;
  logic              in_cmd;
  logic              in_resp;
  logic              a_ack, b_ack;
  logic              mem_read, mem_write;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.b_req, bus.a_req}),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Out-of-range only ever asserts when the bounds check is built in.
  assign oob     = BoundsEn && ({1'b0, addr_q} >= DepthLimit);
  assign in_cmd  = (state_q == ST_CMD);
  assign in_resp = (state_q == ST_RESP);

  // Next-state logic: grant and latch in IDLE, capture read data at the end of CMD.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_d      = gnt_id;
          last_grant_d = gnt_id;
          if (gnt_id == GNT_B) begin
            we_d    = bus.b_we;
            addr_d  = bus.b_addr;
            wdata_d = bus.b_wdata;
          end else begin
            we_d    = bus.a_we;
            addr_d  = bus.a_addr;
            wdata_d = bus.a_wdata;
          end
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        // Memory has already driven READ_DATA at the falling edge inside CMD.
        rdata_d = (!we_q && !oob) ? bus.mem_rdata : '0;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and transaction registers; reset leaves last_grant at B so A wins the first tie.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_A;
      last_grant_q <= GNT_B;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Output decode: one-cycle memory strobe in CMD, one-cycle ack to the granted port in RESP.
  always_comb begin
    mem_read  = in_cmd && !we_q && !oob;
    mem_write = in_cmd &&  we_q && !oob;
    a_ack     = in_resp && (grant_q == GNT_A);
    b_ack     = in_resp && (grant_q == GNT_B);
  end

  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  // Address and data only change when a new grant is latched, so they hold outside CMD.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.a_ack   = a_ack;
  assign bus.a_rdata = a_ack ? rdata_q : '0;
  assign bus.a_err   = a_ack && oob;
  assign bus.b_ack   = b_ack;
  assign bus.b_rdata = b_ack ? rdata_q : '0;
  assign bus.b_err   = b_ack && oob;

  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: drives batches of accesses on both ports, predicts the
// transaction-level outcome (grant order, data, err, ack cycle) from the arbitration
// rules, and checks each ack from a separate monitor against the predictions.
module tb_dmem_arbiter;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic busy;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MEM_DEPTH (DEPTH)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .bus  (bus),
    .busy (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } op_t;

  typedef struct {
    bit         port;   // 0 = A, 1 = B
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } exp_t;

  op_t        a_ops[$];
  op_t        b_ops[$];
  exp_t       exp_q[$];
  logic [7:0] ref_mem[256];
  bit         ref_last;        // port that received the previous grant
  logic [7:0] mem[256];        // backs the whole address space so unchecked accesses are defined
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  function automatic logic [7:0] init_val(input int i);
    if (i == 'h13) return 8'hFD;
    return i[7:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {17'd0, busy, bus.a_ack, bus.b_ack, bus.a_err, bus.b_err, bus.mem_read,
            bus.mem_write, bus.a_rdata, bus.b_rdata, bus.mem_addr, bus.mem_wdata};
  endfunction

  // Data memory model: acts on the falling edge, shares the reset.
  always @(negedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      bus.mem_rdata <= '0;
    end else begin
      if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
      if (bus.mem_read)  bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: invariants every cycle, and scoreboard comparison on every ack.
  initial begin
    int         strobe_cyc;
    logic       strobe_we;
    logic [7:0] strobe_addr;
    logic [7:0] strobe_wdata;
    exp_t       e;
    bit         got_port;
    strobe_cyc = -10;
    forever begin
      @(negedge CLK);
      if (RST) begin
        strobe_cyc = -10;
      end else begin
        check("no_dual_strobe", bus.mem_read & bus.mem_write, 0);
        check("no_dual_ack", bus.a_ack & bus.b_ack, 0);
        if (bus.mem_read | bus.mem_write) begin
          check("strobe_one_cycle", strobe_cyc == cyc - 1, 0);
          strobe_cyc   = cyc;
          strobe_we    = bus.mem_write;
          strobe_addr  = bus.mem_addr;
          strobe_wdata = bus.mem_wdata;
        end
        if (bus.a_ack | bus.b_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ack: a_ack=%0b b_ack=%0b, required no ack", bus.a_ack,
                     bus.b_ack);
          end else begin
            e        = exp_q.pop_front();
            got_port = bus.b_ack;
            check("ack_port", got_port, e.port);
            check("rdata", got_port ? bus.b_rdata : bus.a_rdata, e.rdata);
            check("err", got_port ? bus.b_err : bus.a_err, e.err);
            check("ack_cycle", cyc, e.cyc);
            check("busy_in_resp", busy, 1);
            if (!e.err) begin
              check("strobe_cycle", strobe_cyc, cyc - 1);
              check("strobe_we", strobe_we, e.we);
              check("strobe_addr", strobe_addr, e.addr);
              if (e.we) check("strobe_wdata", strobe_wdata, e.wdata);
            end else begin
              check("oob_no_strobe", strobe_cyc == cyc - 1, 0);
            end
          end
        end
      end
    end
  end

  task automatic ref_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_last = 1'b1;
  endtask

  task automatic load_a();
    if (a_ops.size() > 0) begin
      bus.a_req   = 1'b1;
      bus.a_we    = a_ops[0].we;
      bus.a_addr  = a_ops[0].addr;
      bus.a_wdata = a_ops[0].wdata;
    end else begin
      bus.a_req = 1'b0;
    end
  endtask

  task automatic load_b();
    if (b_ops.size() > 0) begin
      bus.b_req   = 1'b1;
      bus.b_we    = b_ops[0].we;
      bus.b_addr  = b_ops[0].addr;
      bus.b_wdata = b_ops[0].wdata;
    end else begin
      bus.b_req = 1'b0;
    end
  endtask

  // Must be called on a falling edge with the arbiter idle.
  task automatic do_reset();
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    RST = 1'b0;
    #1;
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_outputs", all_outs(), 0);
    RST = 1'b0;
    ref_reset();
  endtask

  // Predict the batch, then drive both ports; each port re-requests right after its ack.
  task automatic run_batch();
    int   ia, ib, k, base, budget;
    bit   p;
    op_t  o;
    exp_t e;
    ia   = 0;
    ib   = 0;
    k    = 0;
    base = cyc + 2;
    while (ia < a_ops.size() || ib < b_ops.size()) begin
      if (ia < a_ops.size() && ib < b_ops.size()) p = ~ref_last;
      else p = (ib < b_ops.size());
      if (p) begin
        o = b_ops[ib];
        ib++;
      end else begin
        o = a_ops[ia];
        ia++;
      end
      e.port  = p;
      e.we    = o.we;
      e.addr  = o.addr;
      e.wdata = o.wdata;
      e.err   = BOUNDS && (o.addr >= DEPTH);
      if (e.err) begin
        e.rdata = 8'h00;
      end else if (o.we) begin
        ref_mem[o.addr] = o.wdata;
        e.rdata = 8'h00;
      end else begin
        e.rdata = ref_mem[o.addr];
      end
      e.cyc    = base + 3 * k;
      k++;
      ref_last = p;
      exp_q.push_back(e);
    end
    load_a();
    load_b();
    budget = 3 * k + 12;
    while ((bus.a_req || bus.b_req) && budget > 0) begin
      @(negedge CLK);
      budget--;
      if (bus.a_ack && a_ops.size() > 0) begin
        void'(a_ops.pop_front());
        load_a();
      end
      if (bus.b_ack && b_ops.size() > 0) begin
        void'(b_ops.pop_front());
        load_b();
      end
    end
    if (bus.a_req || bus.b_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL batch_timeout: %0d ops still pending, required 0", a_ops.size() + b_ops.size());
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
      a_ops.delete();
      b_ops.delete();
      repeat (6) @(negedge CLK);
      exp_q.delete();
    end else begin
      @(negedge CLK);
      check("scoreboard_drained", exp_q.size(), 0);
    end
  endtask

  function automatic op_t mk(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
    op_t o;
    o.we    = we;
    o.addr  = addr;
    o.wdata = wdata;
    return o;
  endfunction

  // Stimulus.
  initial begin
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    do_reset();

    // Tie right after reset: A then B.
    a_ops.push_back(mk(1'b0, 8'h05, 8'h00));
    b_ops.push_back(mk(1'b0, 8'h13, 8'h00));
    run_batch();
    do_reset();

    // Single reads.
    a_ops.push_back(mk(1'b0, 8'h05, 8'h00));
    run_batch();
    a_ops.push_back(mk(1'b0, 8'h13, 8'h00));
    run_batch();

    // Write on A, read back on B.
    a_ops.push_back(mk(1'b1, 8'h0A, 8'h5A));
    run_batch();
    b_ops.push_back(mk(1'b0, 8'h0A, 8'h00));
    run_batch();

    // Reset during CMD of an A write; the write must not land and no ack may follow.
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h01; bus.a_wdata = 8'hFF;
    @(posedge CLK);
    #1;
    check("cmd_write_strobe", bus.mem_write, 1);
    check("cmd_addr", bus.mem_addr, 8'h01);
    RST = 1'b1;
    #1;
    check("reset_mid_outputs", all_outs(), 0);
    bus.a_req = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    ref_reset();
    a_ops.push_back(mk(1'b0, 8'h01, 8'h00));
    run_batch();

    // Sustained contention, three each.
    for (int i = 0; i < 3; i++) begin
      a_ops.push_back(mk(1'(i % 2), 8'(i + 2), 8'(8'hA0 + i)));
      b_ops.push_back(mk(1'b0, 8'(i + 3), 8'h00));
    end
    run_batch();

    // Out-of-range read on B.
    b_ops.push_back(mk(1'b0, 8'h20, 8'h00));
    run_batch();

    // Randomised batches.
    for (int t = 0; t < 15; t++) begin
      int na, nb;
      na = $urandom_range(0, 3);
      nb = $urandom_range(0, 3);
      if (na == 0 && nb == 0) na = 1;
      for (int i = 0; i < na + nb; i++) begin
        op_t o;
        o.we    = 1'($urandom_range(0, 1));
        o.addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(32, 255))
                                              : 8'($urandom_range(0, 31));
        o.wdata = 8'($urandom);
        if (i < na) a_ops.push_back(o);
        else b_ops.push_back(o);
      end
      run_batch();
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
